branch_predict_resolve: RTL and testbench
=========================================

Name: branch_predict_resolve

Overview:
Parametrised successor to decode-stage next-PC selection. Holds a branch history table (BHT) of 2-bit saturating counters indexed by PC, and gives a registered taken/not-taken prediction to fetch. Resolves branches in execute, covering all six RV32I conditions including unsigned, drives pc_input_sel, flags mispredicts and trains the BHT. Sits between fetch (prediction) and execute (resolution/redirect).

Parameters:
XLEN, 32, PC/data width
BHT_ENTRIES, 64, BHT depth; power of two, >= 2; IDX_W = $clog2(BHT_ENTRIES)
BHT_INIT, 2'b01, counter value after reset (weakly not-taken)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
fetch_valid  in  1  fetch_pc is valid this cycle
fetch_pc  in  XLEN  PC being fetched
pred_valid  out  1  registered: pred_taken valid (fetch_valid delayed 1 cycle)
pred_taken  out  1  registered: predicted direction for the previous cycle's fetch_pc
ex_valid  in  1  execute-stage instruction valid
ex_opcode  in  opcode_t  execute opcode
ex_funct3  in  funct3_t  execute funct3
ex_pc  in  XLEN  PC of execute instruction (BHT update index)
ex_pred_taken  in  1  prediction carried down the pipe with the instruction
branch_cmp_eq  in  1  rs1 == rs2
branch_cmp_lt  in  1  rs1 < rs2, signed
branch_cmp_ltu  in  1  rs1 < rs2, unsigned
pc_input_sel  out  pc_input_sel_t  combinational: actual next-PC source for execute instruction
mispredict  out  1  registered 1-cycle pulse: branch direction was wrong

Behaviour:
- Index: idx = pc[IDX_W+1:2]. Bits [1:0] are ignored.
- Reset (sync): all BHT entries = BHT_INIT; pred_valid = 0, pred_taken = 0, mispredict = 0; pc_input_sel = PC_INPUT_PC_PLUS_4 while reset is high. Reset mid-operation drops any pending update and any pending mispredict pulse.
- Prediction, 1-cycle latency: on each clk, pred_valid <= fetch_valid; pred_taken <= BHT[idx(fetch_pc)][1] when fetch_valid; otherwise pred_taken <= 0.
- Read/write collision: if a BHT update targets the same index read by fetch in the same cycle, pred_taken uses the post-update counter (write-first bypass).
- Resolution (combinational), taken = f(funct3):
  - 000 BEQ -> eq
  - 001 BNE -> !eq
  - 100 BLT -> lt
  - 101 BGE -> !lt
  - 110 BLTU -> ltu
  - 111 BGEU -> !ltu
  - 010/011 -> not taken, treated as non-branch (no update, no mispredict)
- pc_input_sel:
  - OPCODE_BRANCH with ex_valid: PC_INPUT_ALU if taken, else PC_INPUT_PC_PLUS_4.
  - OPCODE_JAL/OPCODE_JALR with ex_valid: PC_INPUT_ALU.
  - Everything else, or !ex_valid: PC_INPUT_PC_PLUS_4.
- Training (on clk, valid legal branch only): counter at idx(ex_pc) increments on taken, decrements on not-taken; saturates at 2'b11 and 2'b00. Jumps never touch the BHT.
- mispredict <= ex_valid & legal branch & (taken != ex_pred_taken). Otherwise 0. Jumps never assert mispredict; their redirect is via pc_input_sel only.
- Back-to-back branches to the same index in consecutive cycles each apply their own step (two taken from 01 -> 11).

Optional Feature:
BRANCH_PREDICT_STATS_EN
- Defined: adds outputs stat_branches [31:0] and stat_mispredicts [31:0]. Both reset to 0. stat_branches increments once per valid legal branch; stat_mispredicts increments in the same cycle the mispredict condition is computed (one cycle before the pulse). Both wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package (instructions/constants): add BRANCH_COND_LTU/GEU to branch_cond_t, widened to full funct3 encoding; bht_ctr_t (2-bit); BHT_CTR_SNT/WNT/WT/ST constants. Existing opcode_t, funct3_t and pc_input_sel_t are reused.
- Sub-module: branch_cond_eval (funct3 + eq/lt/ltu -> taken, legal), pure combinational; reused by other pipeline variants.

Test Plan:
- Reset, then fetch_valid=1 with fetch_pc=0x100 -> next cycle pred_valid=1, pred_taken=0 (BHT_INIT=01); no mispredict.
- BEQ at ex_pc=0x100, eq=1, ex_pred_taken=0 -> pc_input_sel=ALU same cycle; mispredict=1 next cycle; counter 01->10; next fetch of 0x100 predicts taken.
- Three taken BLTU at 0x200 (ltu=1) then one not-taken -> counter 01->10->11->11->10; prediction stays taken. Signed lt=0 is ignored for BLTU.
- Alias/collision with BHT_ENTRIES=64: update at ex_pc=0x104 while fetching 0x104 (and aliased 0x204) -> pred_taken reflects the new counter (bypass).
- JAL, funct3=010 branch, ex_valid=0 branch -> JAL selects ALU with no mispredict/update; funct3=010 gives PC+4 and no update; invalid gives PC+4.
- Reset asserted in the cycle after a mispredicting branch -> mispredict stays 0 and BHT entries return to 01; with BRANCH_PREDICT_STATS_EN, stats return to 0.

Source files
------------

// File: rtl/branch_predict_resolve_pkg.sv
// Shared pipeline types for branch prediction and resolution.
//   opcode_t        : RV32I major opcodes (execute-stage decode)
//   funct3_t        : instruction funct3 field
//   branch_cond_t   : branch condition, full funct3 encoding incl. unsigned forms
//   pc_input_sel_t  : next-PC source select
//   bht_ctr_t       : 2-bit saturating BHT counter and its named states
package branch_predict_resolve_pkg;

    typedef enum logic [6:0] {
        OPCODE_LOAD   = 7'b0000011,
        OPCODE_OP_IMM = 7'b0010011,
        OPCODE_AUIPC  = 7'b0010111,
        OPCODE_STORE  = 7'b0100011,
        OPCODE_OP     = 7'b0110011,
        OPCODE_LUI    = 7'b0110111,
        OPCODE_BRANCH = 7'b1100011,
        OPCODE_JALR   = 7'b1100111,
        OPCODE_JAL    = 7'b1101111,
        OPCODE_SYSTEM = 7'b1110011
    } opcode_t;

    typedef logic [2:0] funct3_t;

    typedef enum logic [2:0] {
        BRANCH_COND_EQ  = 3'b000,
        BRANCH_COND_NE  = 3'b001,
        BRANCH_COND_LT  = 3'b100,
        BRANCH_COND_GE  = 3'b101,
        BRANCH_COND_LTU = 3'b110,
        BRANCH_COND_GEU = 3'b111
    } branch_cond_t;

    typedef enum logic [1:0] {
        PC_INPUT_PC_PLUS_4 = 2'b00,
        PC_INPUT_ALU       = 2'b01
    } pc_input_sel_t;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t BHT_CTR_SNT = 2'b00;
    localparam bht_ctr_t BHT_CTR_WNT = 2'b01;
    localparam bht_ctr_t BHT_CTR_WT  = 2'b10;
    localparam bht_ctr_t BHT_CTR_ST  = 2'b11;

    // One saturating training step toward the resolved direction.
    function automatic bht_ctr_t bht_ctr_step(input bht_ctr_t ctr, input logic taken);
        bht_ctr_t result;
        result = ctr;
        if (taken) begin
            if (ctr != BHT_CTR_ST) result = bht_ctr_t'(ctr + 2'd1);
        end else begin
            if (ctr != BHT_CTR_SNT) result = bht_ctr_t'(ctr - 2'd1);
        end
        return result;
    endfunction

endpackage

// File: rtl/branch_predict_resolve_cond_eval.sv
// branch_cond_eval: pure combinational branch condition evaluation.
//   funct3   in  : branch funct3
//   eq/lt/ltu in : rs1==rs2, rs1<rs2 signed, rs1<rs2 unsigned
//   taken_c  out : branch condition holds (0 for reserved encodings)
//   legal_c  out : funct3 is one of the six defined branch conditions
module branch_cond_eval
    import branch_predict_resolve_pkg::*;
(
    input  funct3_t funct3,
    input  logic    eq,
    input  logic    lt,
    input  logic    ltu,
    output logic    taken_c,
    output logic    legal_c
);

    always_comb begin
        taken_c = 1'b0;
        legal_c = 1'b1;
        case (funct3)
            BRANCH_COND_EQ:  taken_c = eq;
            BRANCH_COND_NE:  taken_c = ~eq;
            BRANCH_COND_LT:  taken_c = lt;
            BRANCH_COND_GE:  taken_c = ~lt;
            BRANCH_COND_LTU: taken_c = ltu;
            BRANCH_COND_GEU: taken_c = ~ltu;
            default:         legal_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict_resolve.sv
// branch_predict_resolve: BHT-based direction prediction for fetch plus
// execute-stage branch resolution, redirect select, mispredict flag and training.
//   clk, reset (sync, active-high)
//   fetch_valid, fetch_pc             : fetch lookup request
//   pred_valid, pred_taken            : registered prediction, 1-cycle latency
//   ex_valid, ex_opcode, ex_funct3,
//   ex_pc, ex_pred_taken              : execute-stage instruction
//   branch_cmp_eq/lt/ltu              : comparator results from execute
//   pc_input_sel                      : combinational next-PC source
//   mispredict                        : registered 1-cycle pulse
// Optional (macro BRANCH_PREDICT_STATS_EN): stat_branches, stat_mispredicts.
module branch_predict_resolve
    import branch_predict_resolve_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter bht_ctr_t    BHT_INIT    = BHT_CTR_WNT
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_valid,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            pred_valid,
    output logic            pred_taken,
    input  logic            ex_valid,
    input  opcode_t         ex_opcode,
    input  funct3_t         ex_funct3,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_pred_taken,
    input  logic            branch_cmp_eq,
    input  logic            branch_cmp_lt,
    input  logic            branch_cmp_ltu,
    output pc_input_sel_t   pc_input_sel,
    output logic            mispredict
`ifdef BRANCH_PREDICT_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    bht_ctr_t         bht [BHT_ENTRIES];
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             cond_taken;
    logic             cond_legal;
    logic             upd_en;
    logic             mispredict_c;
    bht_ctr_t         upd_next;
    bht_ctr_t         fetch_ctr;
    logic             unused_pc_bits;

    assign fetch_idx = fetch_pc[IDX_W+1:2];
    assign ex_idx    = ex_pc[IDX_W+1:2];

    // Word-offset and tag bits do not participate in the index.
    assign unused_pc_bits = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0],
                              ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

    branch_cond_eval u_cond_eval (
        .funct3  (ex_funct3),
        .eq      (branch_cmp_eq),
        .lt      (branch_cmp_lt),
        .ltu     (branch_cmp_ltu),
        .taken_c (cond_taken),
        .legal_c (cond_legal)
    );

    // Resolution, training step and write-first fetch lookup.
    always_comb begin
        upd_en       = ex_valid && (ex_opcode == OPCODE_BRANCH) && cond_legal;
        mispredict_c = upd_en && (cond_taken != ex_pred_taken);
        upd_next     = bht_ctr_step(bht[ex_idx], cond_taken);
        fetch_ctr    = (upd_en && (ex_idx == fetch_idx)) ? upd_next : bht[fetch_idx];
    end

    // Next-PC source for the execute instruction; reserved branch encodings resolve not-taken.
    always_comb begin
        pc_input_sel = PC_INPUT_PC_PLUS_4;
        if (!reset && ex_valid) begin
            case (ex_opcode)
                OPCODE_BRANCH: if (cond_taken) pc_input_sel = PC_INPUT_ALU;
                OPCODE_JAL,
                OPCODE_JALR:   pc_input_sel = PC_INPUT_ALU;
                default:       pc_input_sel = PC_INPUT_PC_PLUS_4;
            endcase
        end
    end

    // BHT storage, prediction and mispredict registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
                bht[IDX_W'(i)] <= BHT_INIT;
            end
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            mispredict <= 1'b0;
        end else begin
            if (upd_en) bht[ex_idx] <= upd_next;
            pred_valid <= fetch_valid;
            pred_taken <= fetch_valid & fetch_ctr[1];
            mispredict <= mispredict_c;
        end
    end

`ifdef BRANCH_PREDICT_STATS_EN
    // Event counters; wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches    <= 32'd0;
            stat_mispredicts <= 32'd0;
        end else begin
            if (upd_en)       stat_branches    <= stat_branches + 32'd1;
            if (mispredict_c) stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed scoreboard bench for branch_predict_resolve (default parameters).
module tb_branch_predict_resolve;
    import branch_predict_resolve_pkg::*;

    logic          clk;
    logic          reset;
    logic          fetch_valid;
    logic [31:0]   fetch_pc;
    logic          pred_valid;
    logic          pred_taken;
    logic          ex_valid;
    opcode_t       ex_opcode;
    funct3_t       ex_funct3;
    logic [31:0]   ex_pc;
    logic          ex_pred_taken;
    logic          branch_cmp_eq;
    logic          branch_cmp_lt;
    logic          branch_cmp_ltu;
    pc_input_sel_t pc_input_sel;
    logic          mispredict;
`ifdef BRANCH_PREDICT_STATS_EN
    logic [31:0]   stat_branches;
    logic [31:0]   stat_mispredicts;
`endif

    branch_predict_resolve dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .pred_valid     (pred_valid),
        .pred_taken     (pred_taken),
        .ex_valid       (ex_valid),
        .ex_opcode      (ex_opcode),
        .ex_funct3      (ex_funct3),
        .ex_pc          (ex_pc),
        .ex_pred_taken  (ex_pred_taken),
        .branch_cmp_eq  (branch_cmp_eq),
        .branch_cmp_lt  (branch_cmp_lt),
        .branch_cmp_ltu (branch_cmp_ltu),
        .pc_input_sel   (pc_input_sel),
        .mispredict     (mispredict)
`ifdef BRANCH_PREDICT_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        pc_input_sel_t sel;
        logic          chk_reg;
        logic          pv;
        logic          pt;
        logic          mp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    localparam pc_input_sel_t S4 = PC_INPUT_PC_PLUS_4;
    localparam pc_input_sel_t SA = PC_INPUT_ALU;
    localparam logic [2:0] F_BEQ  = 3'b000;
    localparam logic [2:0] F_BNE  = 3'b001;
    localparam logic [2:0] F_010  = 3'b010;
    localparam logic [2:0] F_011  = 3'b011;
    localparam logic [2:0] F_BLT  = 3'b100;
    localparam logic [2:0] F_BGE  = 3'b101;
    localparam logic [2:0] F_BLTU = 3'b110;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Monitor: sample mid-cycle and compare against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.name, ".pc_input_sel"}, int'(pc_input_sel), int'(e.sel));
            if (e.chk_reg) begin
                chk({e.name, ".pred_valid"}, int'(pred_valid), int'(e.pv));
                chk({e.name, ".pred_taken"}, int'(pred_taken), int'(e.pt));
                chk({e.name, ".mispredict"}, int'(mispredict), int'(e.mp));
            end
        end
    end

    // One cycle: drive inputs, queue expectations (sel for these inputs,
    // registered outputs from the previous cycle), then advance a clock.
    task automatic cyc(input string name, input logic r,
                       input logic fv, input logic [31:0] fpc,
                       input logic ev, input opcode_t op, input logic [2:0] f3,
                       input logic [31:0] epc, input logic ept,
                       input logic eq, input logic lt, input logic ltu,
                       input pc_input_sel_t esel, input logic ck,
                       input logic epv, input logic ept_o, input logic emp);
        exp_t e;
        reset          = r;
        fetch_valid    = fv;
        fetch_pc       = fpc;
        ex_valid       = ev;
        ex_opcode      = op;
        ex_funct3      = f3;
        ex_pc          = epc;
        ex_pred_taken  = ept;
        branch_cmp_eq  = eq;
        branch_cmp_lt  = lt;
        branch_cmp_ltu = ltu;
        e.name    = name;
        e.sel     = esel;
        e.chk_reg = ck;
        e.pv      = epv;
        e.pt      = ept_o;
        e.mp      = emp;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        fetch_valid = 1'b0; fetch_pc = '0; ex_valid = 1'b0; ex_opcode = OPCODE_OP;
        ex_funct3 = '0; ex_pc = '0; ex_pred_taken = 1'b0;
        branch_cmp_eq = 1'b0; branch_cmp_lt = 1'b0; branch_cmp_ltu = 1'b0;
        @(posedge clk);
        #1;
        //   name        rst fv fpc     ev op             f3      epc     ept eq lt ltu sel ck pv pt mp
        cyc("rst_jal",   1, 0, 32'h0,   1, OPCODE_JAL,    F_BEQ,  32'h0,   0, 0, 0, 0, S4, 0, 0, 0, 0);
        cyc("rst_hold",  1, 0, 32'h0,   0, OPCODE_OP,     F_BEQ,  32'h0,   0, 0, 0, 0, S4, 1, 0, 0, 0);
        cyc("fetch100",  0, 1, 32'h100, 0, OPCODE_OP,     F_BEQ,  32'h0,   0, 0, 0, 0, S4, 1, 0, 0, 0);
        cyc("beq_tkn",   0, 0, 32'h0,   1, OPCODE_BRANCH, F_BEQ,  32'h100, 0, 1, 0, 0, SA, 1, 1, 0, 0);
        cyc("refetch",   0, 1, 32'h100, 0, OPCODE_OP,     F_BEQ,  32'h0,   0, 0, 0, 0, S4, 1, 0, 0, 1);
        cyc("pred_tkn",  0, 0, 32'h0,   0, OPCODE_OP,     F_BEQ,  32'h0,   0, 0, 0, 0, S4, 1, 1, 1, 0);
        // BLTU training at idx 2, signed compare must not matter
        cyc("bltu1",     0, 0, 32'h0,   1, OPCODE_BRANCH, F_BLTU, 32'h208, 0, 0, 0, 1, SA, 1, 0, 0, 0);
        cyc("bltu2",     0, 0, 32'h0,   1, OPCODE_BRANCH, F_BLTU, 32'h208, 1, 0, 0, 1, SA, 1, 0, 0, 1);
        cyc("bltu3_sat", 0, 0, 32'h0,   1, OPCODE_BRANCH, F_BLTU, 32'h208, 1, 0, 0, 1, SA, 1, 0, 0, 0);
        cyc("bltu_nt",   0, 1, 32'h208, 1, OPCODE_BRANCH, F_BLTU, 32'h208, 1, 0, 1, 0, S4, 1, 0, 0, 0);
        cyc("fetch208",  0, 1, 32'h208, 0, OPCODE_OP,     F_BEQ,  32'h0,   0, 0, 0, 0, S4, 1, 1, 1, 1);
        cyc("bltu_nt2",  0, 1, 32'h208, 1, OPCODE_BRANCH, F_BLTU, 32'h208, 1, 0, 1, 0, S4, 1, 1, 1, 0);
        cyc("after_nt2", 0, 0, 32'h0,   0, OPCODE_OP,     F_BEQ,  32'h0,   0, 0, 0, 0, S4, 1, 1, 0, 1);
        // Same-cycle update/fetch collisions at idx 1 (0x104 and alias 0x204)
        cyc("bne_byp",   0, 1, 32'h104, 1, OPCODE_BRANCH, F_BNE,  32'h104, 0, 0, 0, 0, SA, 1, 0, 0, 0);
        cyc("bge_alias", 0, 1, 32'h204, 1, OPCODE_BRANCH, F_BGE,  32'h104, 1, 0, 1, 0, S4, 1, 1, 1, 1);
        cyc("alias_rd",  0, 1, 32'h204, 0, OPCODE_OP,     F_BEQ,  32'h0,   0, 0, 0, 0, S4, 1, 1, 0, 1);
        cyc("blt_ok",    0, 1, 32'h10C, 1, OPCODE_BRANCH, F_BLT,  32'h104, 1, 0, 1, 0, SA, 1, 1, 0, 0);
        cyc("idle1",     0, 0, 32'h0,   0, OPCODE_OP,     F_BEQ,  32'h0,   0, 0, 0, 0, S4, 1, 1, 0, 0);
        // Non-branch traffic must not train or flag
        cyc("jal",       0, 0, 32'h0,   1, OPCODE_JAL,    F_BEQ,  32'h104, 0, 0, 0, 0, SA, 1, 0, 0, 0);
        cyc("jalr",      0, 0, 32'h0,   1, OPCODE_JALR,   F_BEQ,  32'h104, 0, 1, 1, 1, SA, 1, 0, 0, 0);
        cyc("f3_010",    0, 0, 32'h0,   1, OPCODE_BRANCH, F_010,  32'h104, 1, 1, 1, 1, S4, 1, 0, 0, 0);
        cyc("f3_011",    0, 0, 32'h0,   1, OPCODE_BRANCH, F_011,  32'h104, 1, 0, 0, 0, S4, 1, 0, 0, 0);
        cyc("inv_beq",   0, 0, 32'h0,   0, OPCODE_BRANCH, F_BEQ,  32'h104, 0, 1, 0, 0, S4, 1, 0, 0, 0);
        cyc("op_rd104",  0, 1, 32'h104, 1, OPCODE_OP,     F_BEQ,  32'h104, 1, 1, 0, 0, S4, 1, 0, 0, 0);
        cyc("idle2",     0, 0, 32'h0,   0, OPCODE_OP,     F_BEQ,  32'h0,   0, 0, 0, 0, S4, 1, 1, 1, 0);
        // Reset after a mispredict, and reset concurrent with a branch
        cyc("beq_10c",   0, 0, 32'h0,   1, OPCODE_BRANCH, F_BEQ,  32'h10C, 0, 1, 0, 0, SA, 1, 0, 0, 0);
        cyc("rst_a",     1, 0, 32'h0,   0, OPCODE_OP,     F_BEQ,  32'h0,   0, 0, 0, 0, S4, 1, 0, 0, 1);
        cyc("rst_b_br",  1, 0, 32'h0,   1, OPCODE_BRANCH, F_BEQ,  32'h10C, 0, 1, 0, 0, S4, 1, 0, 0, 0);
        cyc("post_rst",  0, 1, 32'h10C, 0, OPCODE_OP,     F_BEQ,  32'h0,   0, 0, 0, 0, S4, 1, 0, 0, 0);
        cyc("rd100",     0, 1, 32'h100, 0, OPCODE_OP,     F_BEQ,  32'h0,   0, 0, 0, 0, S4, 1, 1, 0, 0);
        cyc("rd104",     0, 1, 32'h104, 0, OPCODE_OP,     F_BEQ,  32'h0,   0, 0, 0, 0, S4, 1, 1, 0, 0);
        cyc("drain1",    0, 0, 32'h0,   0, OPCODE_OP,     F_BEQ,  32'h0,   0, 0, 0, 0, S4, 1, 1, 0, 0);
        cyc("drain2",    0, 0, 32'h0,   0, OPCODE_OP,     F_BEQ,  32'h0,   0, 0, 0, 0, S4, 1, 0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
